// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32 control FSM.
// Optional perf counters are enabled by defining MC_PERF_CNT_EN.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } mc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // One bundle of every decoded control output; all-zero is the idle value.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the control FSM (master) and the datapath (slave).
// Optional perf counters (MC_PERF_CNT_EN) are plain top-level ports, not part of this bundle.
interface multicycle_ctrl_fsm_if;
  import riscv_ctrl_pkg::*;

  // Memory handshake: an access completes in a cycle where mem_req and mem_ready are
  // both high; mem_req, adr_src and mem_write stay stable until that cycle.
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_op;
  logic       illegal_instr;
  mc_state_t  dbg_state;

  modport master (
    input  op, funct3, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, illegal_instr, dbg_state
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, illegal_instr, dbg_state
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_perf_counters.sv
// Cycle and retired-instruction counters for the control FSM (used under MC_PERF_CNT_EN).
// Both wrap naturally at 2**CNT_W.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instret_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instret_inc) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32 core: state register, next-state and output decode.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.master ctrl
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  mc_state_t state;
  mc_state_t state_d;
  logic      illegal_q;
  ctrl_t     c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH:    if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          // Only BEQ is implemented among the branches.
          OP_BRANCH:         state_d = (ctrl.funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = ctrl.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ctrl.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ctrl.mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe so an aborted instruction cannot write anything.
  always_comb begin
    c = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          c.mem_req    = 1'b1;
          c.alu_src_a  = SRCA_PC;
          c.alu_src_b  = SRCB_FOUR;
          c.alu_op     = ALU_ADD;
          c.result_src = RES_ALURESULT;
          c.ir_write   = ctrl.mem_ready;
          c.pc_write   = ctrl.mem_ready;
        end
        S_DECODE: begin
          c.alu_src_a = SRCA_OLDPC;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end
        S_MEMADR: begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_ADD;
        end
        S_MEMREAD: begin
          c.mem_req = 1'b1;
          c.adr_src = 1'b1;
        end
        S_MEMWB: begin
          c.result_src = RES_DATA;
          c.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          c.mem_req   = 1'b1;
          c.mem_write = 1'b1;
          c.adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_RS2;
          c.alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_IMM;
          c.alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          c.result_src = RES_ALUOUT;
          c.reg_write  = 1'b1;
        end
        S_BEQ: begin
          c.alu_src_a  = SRCA_RS1;
          c.alu_src_b  = SRCB_RS2;
          c.alu_op     = ALU_SUB;
          c.result_src = RES_ALUOUT;
          c.pc_write   = ctrl.zero;
        end
        S_JAL: begin
          c.alu_src_a  = SRCA_OLDPC;
          c.alu_src_b  = SRCB_FOUR;
          c.alu_op     = ALU_ADD;
          c.result_src = RES_ALUOUT;
          c.pc_write   = 1'b1;
        end
        default: c = '0;
      endcase
    end
  end

  assign ctrl.mem_req       = c.mem_req;
  assign ctrl.mem_write     = c.mem_write;
  assign ctrl.adr_src       = c.adr_src;
  assign ctrl.ir_write      = c.ir_write;
  assign ctrl.pc_write      = c.pc_write;
  assign ctrl.reg_write     = c.reg_write;
  assign ctrl.alu_src_a     = c.alu_src_a;
  assign ctrl.alu_src_b     = c.alu_src_b;
  assign ctrl.result_src    = c.result_src;
  assign ctrl.alu_op        = c.alu_op;
  assign ctrl.illegal_instr = illegal_q;
  assign ctrl.dbg_state     = state;

`ifdef MC_PERF_CNT_EN
  logic instret_inc;

  // TRAP never returns to FETCH on its own, so it never retires.
  assign instret_inc = (state != S_FETCH) && (state_d == S_FETCH);

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .instret_inc (instret_inc),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  // CNT_W only sizes the counters; this keeps it referenced in the counter-less build.
  if (CNT_W < 1) begin : g_bad_cnt_w
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle vector table, random-stall latency runs,
// and (with MC_PERF_CNT_EN) counter checks at CNT_W=4.
module tb_multicycle_ctrl_fsm;
  import riscv_ctrl_pkg::*;

  localparam int CW = 4;
  localparam int VW = 19;

  logic clk = 1'b0;
  logic rst;

  multicycle_ctrl_fsm_if bus ();

`ifdef MC_PERF_CNT_EN
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instret_cnt;
`endif

  multicycle_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        mr;
    mc_state_t   st;
    logic [63:0] tag;
  } step_t;

  step_t           steps[$];
  logic [VW-1:0]   exp_q[$];
  logic [VW-1:0]   msk_q[$];
  logic [7:0]      lat_q[$];
  int              total = 0;
  int              bad   = 0;

  // Expected outputs from the control table: {state, illegal, strobes, selects}.
  function automatic logic [VW-1:0] exp_vec(mc_state_t s, logic r, logic z, logic mr);
    logic       mreq, mw, adr, irw, pcw, rw, ill;
    logic [1:0] a, b, res, aop;
    mreq = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0;
    a = 0; b = 0; res = 0; aop = 0;
    ill = (s == S_TRAP);
    if (!r) begin
      case (s)
        S_FETCH:    begin mreq = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
        S_DECODE:   begin a = 2'b01; b = 2'b01; end
        S_MEMADR:   begin a = 2'b10; b = 2'b01; end
        S_MEMREAD:  begin mreq = 1; adr = 1; end
        S_MEMWB:    begin res = 2'b01; rw = 1; end
        S_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
        S_EXEC_R:   begin a = 2'b10; b = 2'b00; aop = 2'b10; end
        S_EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
        S_ALUWB:    begin rw = 1; end
        S_BEQ:      begin a = 2'b10; aop = 2'b01; pcw = z; end
        S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
        default:    ;
      endcase
    end
    return {4'(s), ill, mreq, mw, adr, irw, pcw, rw, a, b, res, aop};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {4'(bus.dbg_state), bus.illegal_instr, bus.mem_req, bus.mem_write, bus.adr_src,
            bus.ir_write, bus.pc_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.result_src, bus.alu_op};
  endfunction

  // driver tasks
  task automatic add_step(input logic r, input logic [6:0] o, input logic [2:0] f,
                          input logic z, input logic m, input mc_state_t s,
                          input logic [63:0] t);
    step_t e;
    e.rst = r; e.op = o; e.f3 = f; e.zero = z; e.mr = m; e.st = s; e.tag = t;
    steps.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic z, input logic m);
    rst = r; bus.op = o; bus.funct3 = f; bus.zero = z; bus.mem_ready = m;
  endtask

  task automatic check_int(input logic [63:0] name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [VW-1:0] act, e, m;
    int            base[6];
    logic [6:0]    ops[6];
    int            n, cyc;
    logic          left, done;

    drive(1'b1, OP_RTYPE, 3'b000, 1'b0, 1'b0);

    // vector table: inputs for one cycle and the state expected during it
    add_step(1, OP_RTYPE,  0, 0, 0, S_FETCH,    "reset");
    add_step(1, OP_RTYPE,  0, 0, 1, S_FETCH,    "reset");
    add_step(0, OP_RTYPE,  0, 0, 1, S_FETCH,    "add");
    add_step(0, OP_RTYPE,  0, 0, 1, S_DECODE,   "add");
    add_step(0, OP_RTYPE,  0, 0, 1, S_EXEC_R,   "add");
    add_step(0, OP_RTYPE,  0, 0, 1, S_ALUWB,    "add");
    add_step(0, OP_LOAD,   0, 0, 1, S_FETCH,    "lw");
    add_step(0, OP_LOAD,   0, 0, 1, S_DECODE,   "lw");
    add_step(0, OP_LOAD,   0, 0, 1, S_MEMADR,   "lw");
    add_step(0, OP_LOAD,   0, 0, 0, S_MEMREAD,  "lw");
    add_step(0, OP_LOAD,   0, 0, 0, S_MEMREAD,  "lw");
    add_step(0, OP_LOAD,   0, 0, 1, S_MEMREAD,  "lw");
    add_step(0, OP_LOAD,   0, 0, 1, S_MEMWB,    "lw");
    add_step(0, OP_BRANCH, 0, 1, 1, S_FETCH,    "beq_t");
    add_step(0, OP_BRANCH, 0, 1, 1, S_DECODE,   "beq_t");
    add_step(0, OP_BRANCH, 0, 1, 1, S_BEQ,      "beq_t");
    add_step(0, OP_BRANCH, 0, 0, 1, S_FETCH,    "beq_nt");
    add_step(0, OP_BRANCH, 0, 0, 1, S_DECODE,   "beq_nt");
    add_step(0, OP_BRANCH, 0, 0, 1, S_BEQ,      "beq_nt");
    add_step(0, OP_STORE,  0, 0, 1, S_FETCH,    "sw");
    add_step(0, OP_STORE,  0, 0, 1, S_DECODE,   "sw");
    add_step(0, OP_STORE,  0, 0, 1, S_MEMADR,   "sw");
    add_step(0, OP_STORE,  0, 0, 0, S_MEMWRITE, "sw");
    add_step(0, OP_STORE,  0, 0, 0, S_MEMWRITE, "sw");
    add_step(0, OP_STORE,  0, 0, 0, S_MEMWRITE, "sw");
    add_step(0, OP_STORE,  0, 0, 1, S_MEMWRITE, "sw");
    add_step(0, OP_ITYPE,  0, 0, 1, S_FETCH,    "addi");
    add_step(0, OP_ITYPE,  0, 0, 1, S_DECODE,   "addi");
    add_step(0, OP_ITYPE,  0, 0, 1, S_EXEC_I,   "addi");
    add_step(0, OP_ITYPE,  0, 0, 1, S_ALUWB,    "addi");
    add_step(0, OP_JAL,    0, 0, 1, S_FETCH,    "jal");
    add_step(0, OP_JAL,    0, 0, 1, S_DECODE,   "jal");
    add_step(0, OP_JAL,    0, 0, 1, S_JAL,      "jal");
    add_step(0, OP_JAL,    0, 0, 1, S_ALUWB,    "jal");
    add_step(0, OP_STORE,  0, 0, 0, S_FETCH,    "sw_rst");
    add_step(0, OP_STORE,  0, 0, 1, S_FETCH,    "sw_rst");
    add_step(0, OP_STORE,  0, 0, 1, S_DECODE,   "sw_rst");
    add_step(0, OP_STORE,  0, 0, 1, S_MEMADR,   "sw_rst");
    add_step(0, OP_STORE,  0, 0, 0, S_MEMWRITE, "sw_rst");
    add_step(1, OP_STORE,  0, 0, 1, S_FETCH,    "sw_rst");
    add_step(0, OP_STORE,  0, 0, 0, S_FETCH,    "post_rst");
    add_step(0, OP_BRANCH, 1, 0, 1, S_FETCH,    "bne");
    add_step(0, OP_BRANCH, 1, 0, 1, S_DECODE,   "bne");
    add_step(0, OP_BRANCH, 1, 0, 1, S_TRAP,     "bne");
    add_step(0, OP_BRANCH, 1, 0, 1, S_TRAP,     "bne");
    add_step(0, OP_BRANCH, 1, 0, 0, S_TRAP,     "bne");
    add_step(1, OP_BRANCH, 1, 0, 1, S_FETCH,    "trap_rst");
    add_step(0, 7'h7F,     0, 0, 1, S_FETCH,    "illop");
    add_step(0, 7'h7F,     0, 0, 1, S_DECODE,   "illop");
    add_step(0, 7'h7F,     0, 0, 1, S_TRAP,     "illop");
    add_step(0, 7'h7F,     0, 1, 1, S_TRAP,     "illop");
    add_step(1, 7'h7F,     0, 0, 1, S_FETCH,    "trap_rst");
    add_step(0, OP_RTYPE,  0, 0, 0, S_FETCH,    "post_rst");

    foreach (steps[i]) begin
      @(posedge clk);
      #1;
      drive(steps[i].rst, steps[i].op, steps[i].f3, steps[i].zero, steps[i].mr);
      exp_q.push_back(exp_vec(steps[i].st, steps[i].rst, steps[i].zero, steps[i].mr));
      // state and the registered flag are not defined until the reset edge has happened
      msk_q.push_back(steps[i].rst ? {5'b0, 14'h3FFF} : {VW{1'b1}});
      @(negedge clk);
      act = act_vec();
      e   = exp_q.pop_front();
      m   = msk_q.pop_front();
      total++;
      if ((act & m) != (e & m)) begin
        bad++;
        $display("FAIL step%0d %s: got %05h, required %05h (mask %05h)",
                 i, steps[i].tag, act, e, m);
      end
    end

    // random FETCH stalls: total latency must grow by exactly one cycle per stall
    ops  = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    base = '{4, 4, 5, 4, 3, 4};
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 3);
      lat_q.push_back(8'(base[k] + n));
      bus.op = ops[k]; bus.funct3 = 3'b000; bus.zero = 1'($urandom_range(0, 1));
      cyc = 0; left = 0; done = 0;
      while (!done && cyc < 40) begin
        @(posedge clk);
        #1;
        bus.mem_ready = (cyc >= n);
        @(negedge clk);
        if (bus.dbg_state != S_FETCH) left = 1;
        else if (left) begin
          done = 1;
          bus.mem_ready = 1'b0;
        end
        if (!done) cyc++;
      end
      if (!done) begin
        total++;
        bad++;
        void'(lat_q.pop_front());
        $display("FAIL latency_timeout op=%07b: got no return to FETCH in %0d cycles, required return",
                 ops[k], cyc);
      end else begin
        check_int("latency", cyc, int'(lat_q.pop_front()));
      end
    end

`ifdef MC_PERF_CNT_EN
    @(posedge clk);
    #1;
    drive(1'b1, OP_RTYPE, 3'b000, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_int("cycle_rst", int'(cycle_cnt), 0);
    check_int("instret_rst", int'(instret_cnt), 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_int("cycle_12", int'(cycle_cnt), 12);
    check_int("instret_3", int'(instret_cnt), 3);
    bus.mem_ready = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_int("cycle_wrap", int'(cycle_cnt), 4);
    check_int("instret_hold", int'(instret_cnt), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
